// File: rtl/lfsr_crypt_seq_pkg.sv
// lfsr_crypt_seq_pkg: shared FSM states, memory map constants and legal tap table for the LFSR crypt sequencer
package lfsr_crypt_seq_pkg;
  typedef enum logic [2:0] {IDLE, CFG0, CFG1, CFG2, CFG3, RD, WR, DONE} state_t;
  localparam int CFG_BASE = 61;
  localparam int OUT_BASE = 64;
  localparam int MAX_MSG = 52;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [6:0] LEGAL_PTRN [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  function automatic logic ptrn_legal(input logic [6:0] p);
    ptrn_legal = 1'b0;
    for (int i = 0; i < 9; i++) if (LEGAL_PTRN[i] == p) ptrn_legal = 1'b1;
  endfunction
endpackage

// File: rtl/lfsr_crypt_seq_if.sv
// lfsr_crypt_seq_if: handshake and data-memory port between the sequencer and its host
interface lfsr_crypt_seq_if #(parameter int ADDR_W = 8);
  logic req, ack, busy, mem_ren, mem_wen, ptrn_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_rdata, mem_wdata;
  modport master(input req, mem_rdata, output ack, busy, mem_addr, mem_ren, mem_wen, mem_wdata, ptrn_err);
  modport slave(output req, mem_rdata, input ack, busy, mem_addr, mem_ren, mem_wen, mem_wdata, ptrn_err);
endinterface

// File: rtl/lfsr_crypt_seq_lfsr7_step.sv
// lfsr7_step: one 7-bit LFSR advance plus the parity-tagged encryption of a character
module lfsr7_step import lfsr_crypt_seq_pkg::*; (
  input  logic [6:0] state,
  input  logic [6:0] ptrn,
  input  logic [6:0] data,
  output logic [6:0] nxt,
  output logic [7:0] enc
);
  logic [6:0] x;
  // only the low 7 bits of (char - space) survive the xor, so bit 7 of the char never matters
  always_comb begin
    x = (data - SPACE[6:0]) ^ state;
    enc = {^x, x};
    nxt = {state[5:0], ^(state & ptrn)};
  end
endmodule

// File: rtl/lfsr_crypt_seq.sv
// lfsr_crypt_seq: DM-owning sequencer for the LFSR encryption pass; LFSR_CRYPT_PTRN_CHECK_EN enables tap-pattern legality checking
module lfsr_crypt_seq import lfsr_crypt_seq_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int MSG_LEN = 64
) (
  input logic clk,
  input logic init,
  lfsr_crypt_seq_if.master bus
);
  localparam int IW = $clog2(MSG_LEN);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [3:0] pre;
  logic [6:0] ptrn, lfsr, lfsr_n;
  logic [7:0] off, enc;
  logic rd_ok, err, in_msg, legal, ren, wen;
  logic [ADDR_W-1:0] addr;
  assign off = 8'(idx) - 8'(pre);
  assign in_msg = 8'(idx) >= 8'(pre) && off < 8'(MAX_MSG);
`ifdef LFSR_CRYPT_PTRN_CHECK_EN
  assign legal = ptrn_legal(bus.mem_rdata[6:0]);
`else
  assign legal = 1'b1;
`endif
  lfsr7_step u_step (
    .state(lfsr),
    .ptrn(ptrn),
    .data(rd_ok ? bus.mem_rdata[6:0] : SPACE[6:0]),
    .nxt(lfsr_n),
    .enc(enc)
  );
  // next state and memory strobes; reads land one cycle later, so each capture sits one state after its read
  always_comb begin
    state_n = state;
    ren = 1'b0;
    wen = 1'b0;
    addr = '0;
    case (state)
      IDLE: state_n = bus.req ? IDLE : CFG0;
      CFG0: begin ren = 1'b1; addr = ADDR_W'(CFG_BASE); state_n = CFG1; end
      CFG1: begin ren = 1'b1; addr = ADDR_W'(CFG_BASE + 1); state_n = CFG2; end
      CFG2: begin ren = 1'b1; addr = ADDR_W'(CFG_BASE + 2); state_n = CFG3; end
      CFG3: state_n = RD;
      RD: begin ren = in_msg; addr = in_msg ? ADDR_W'(off) : '0; state_n = WR; end
      WR: begin wen = 1'b1; addr = ADDR_W'(OUT_BASE) + ADDR_W'(idx); state_n = idx == IW'(MSG_LEN - 1) ? DONE : RD; end
      DONE: state_n = bus.req ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.mem_ren = ren;
  assign bus.mem_wen = wen;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = state == WR ? enc : 8'h00;
  assign bus.ack = state == DONE;
  assign bus.busy = state != IDLE && state != DONE;
  assign bus.ptrn_err = err;
  // state, byte index, captured config and LFSR; idx holds at the last byte and clears on leaving DONE
  always_ff @(posedge clk) begin
    if (init) begin
      state <= IDLE;
      idx <= '0;
      pre <= '0;
      ptrn <= '0;
      lfsr <= '0;
      rd_ok <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (!bus.req) begin idx <= '0; err <= 1'b0; end
        CFG1: pre <= bus.mem_rdata[3:0];
        CFG2: begin ptrn <= legal ? bus.mem_rdata[6:0] : 7'h60; err <= err | ~legal; end
        CFG3: lfsr <= bus.mem_rdata[6:0] == 7'h00 ? 7'h01 : bus.mem_rdata[6:0];
        RD: rd_ok <= in_msg;
        WR: begin lfsr <= lfsr_n; idx <= idx == IW'(MSG_LEN - 1) ? idx : idx + 1'b1; end
        DONE: if (bus.req) idx <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_crypt_seq.sv
// tb_lfsr_crypt_seq: directed bench with a 1-cycle-latency DM model and a golden encryption model
module tb_lfsr_crypt_seq;
  logic clk = 1'b0;
  logic init;
  logic [7:0] dm [0:255];
  logic [7:0] msg [0:51];
  logic [7:0] exp_b [0:63];
  logic ld_en = 1'b0;
  logic [7:0] ld_addr, ld_data;
  int wen_cnt = 0, ovl = 0, checks = 0, errors = 0;
  lfsr_crypt_seq_if bus ();
  lfsr_crypt_seq dut (.clk(clk), .init(init), .bus(bus));
  always #5 clk = ~clk;
  // single-port DM: bench loads take the port only while the sequencer is idle
  always @(posedge clk) begin
    if (ld_en) dm[ld_addr] <= ld_data;
    else if (bus.mem_wen) dm[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_ren) bus.mem_rdata <= dm[bus.mem_addr];
    if (bus.mem_ren && bus.mem_wen) ovl <= ovl + 1;
    if (bus.mem_wen) wen_cnt <= wen_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic poke(input int a, input logic [7:0] d);
    ld_addr = 8'(a);
    ld_data = d;
    ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask
  task automatic gold(input logic [3:0] pre, input logic [6:0] p, input logic [6:0] i0);
    logic [6:0] l, x;
    logic [7:0] b, c;
    int kp;
    l = i0 == 7'h00 ? 7'h01 : i0;
    for (int k = 0; k < 64; k++) begin
      kp = k - int'(pre);
      b = (kp >= 0 && kp < 52) ? msg[kp] : 8'h20;
      c = b - 8'h20;
      x = c[6:0] ^ l;
      exp_b[k] = {^x, x};
      l = {l[5:0], ^(l & p)};
    end
  endtask
  task automatic prep(input string s, input logic [7:0] pre, input logic [7:0] p, input logic [7:0] i0, input logic [6:0] gp);
    for (int i = 0; i < 52; i++) begin
      msg[i] = i < s.len() ? s[i] : 8'h20;
      poke(i, msg[i]);
    end
    poke(61, pre);
    poke(62, p);
    poke(63, i0);
    gold(pre[3:0], gp, i0[6:0]);
    for (int k = 0; k < 64; k++) poke(64 + k, ~exp_b[k]);
  endtask
  task automatic cmp_out(input string tag);
    int ok = 0;
    for (int k = 0; k < 64; k++) if (dm[64 + k] === exp_b[k]) ok++;
    check(tag, ok, 64);
  endtask
  task automatic run(input int pulse_at, input int abort_at);
    int n = 0, w0, w1;
    w0 = wen_cnt;
    @(negedge clk) bus.req = 1'b0;
    @(posedge clk);
    do begin
      @(posedge clk);
      #1 n++;
      if (n == 1) check("busy_run", bus.busy, 1);
      if (n == pulse_at) bus.req = 1'b1;
      if (n == pulse_at + 2) bus.req = 1'b0;
      if (n == abort_at) begin
        init = 1'b1;
        bus.req = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        w1 = wen_cnt;
        repeat (10) @(posedge clk);
        #1 check("abort_no_wr", wen_cnt - w1, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_ack", bus.ack, 0);
        return;
      end
    end while (!bus.ack && n < 300);
    check("ack_latency", n, 132);
    check("wen_total", wen_cnt - w0, 64);
    check("busy_done", bus.busy, 0);
    @(negedge clk) bus.req = 1'b1;
    @(posedge clk);
    #1 check("ack_drop", bus.ack, 0);
  endtask
  initial begin
    init = 1'b1;
    bus.req = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("rst_ack", bus.ack, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ren", bus.mem_ren, 0);
    check("rst_wen", bus.mem_wen, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_err", bus.ptrn_err, 0);
    init = 1'b0;
    prep("Mr. Watson, come here. I want to see you.", 8'd10, 8'h60, 8'h01, 7'h60);
    run(0, 0);
    cmp_out("t1_out");
    check("t1_dm64", dm[64], 8'h81);
    check("t1_dm65", dm[65], 8'h82);
    prep("Mr. Watson, come here. I want to see you.", 8'd10, 8'h48, 8'h00, 7'h48);
    run(0, 0);
    cmp_out("t2_init0_out");
    check("t2_dm64", dm[64], 8'h81);
    prep("The quick brown fox jumps over the lazy dog 12345678", 8'd15, 8'h60, 8'h5A, 7'h60);
    run(0, 0);
    cmp_out("t3_pad_out");
    prep("Mr. Watson, come here. I want to see you.", 8'd3, 8'h6A, 8'h33, 7'h6A);
    run(0, 40);
    run(0, 0);
    cmp_out("t4_relaunch_out");
    prep("Mr. Watson, come here. I want to see you.", 8'd0, 8'h5C, 8'h7F, 7'h5C);
    run(50, 0);
    cmp_out("t5_req_pulse_out");
`ifdef LFSR_CRYPT_PTRN_CHECK_EN
    prep("Mr. Watson, come here. I want to see you.", 8'd10, 8'h11, 8'h01, 7'h60);
    run(0, 0);
    check("t6_ptrn_err", bus.ptrn_err, 1);
`else
    prep("Mr. Watson, come here. I want to see you.", 8'd10, 8'h11, 8'h01, 7'h11);
    run(0, 0);
    check("t6_ptrn_err", bus.ptrn_err, 0);
`endif
    cmp_out("t6_out");
    check("ren_wen_excl", ovl, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
